// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// dmem_access_ctrl : MEM-stage data-memory sequencer with stall/bubble control
// Revision 1.0
// ============================================================================
module dmem_access_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int DATA_W  = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MEM_READ,
    input  logic              MEM_WRITE,
    input  logic [DATA_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] MEM_WDATA,
    output logic              DMEM_REQ,
    output logic              DMEM_WE,
    output logic [DATA_W-1:0] DMEM_ADDR,
    output logic [DATA_W-1:0] DMEM_WDATA,
    input  logic              DMEM_ACK,
    input  logic [DATA_W-1:0] DMEM_RDATA,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              PIPE_STALL,
    output logic              WB_BUBBLE,
    output logic              MEM_ERR
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] count;
    logic       access_req;
    logic       misaligned;
    logic       issue;
    logic       ack_take;
    logic       timed_out;
    logic       bad_access;

    assign access_req = MEM_READ | MEM_WRITE;
    assign misaligned = |MEM_ADDR[1:0];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE ignores MEM_READ/MEM_WRITE: they still describe the finished access.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        ack_take   = 1'b0;
        timed_out  = 1'b0;
        bad_access = 1'b0;
        PIPE_STALL = 1'b0;
        case (state)
            IDLE: begin
                if (access_req) begin
                    if (misaligned) begin
                        bad_access = 1'b1;
                    end else begin
                        issue      = 1'b1;
                        PIPE_STALL = 1'b1;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                PIPE_STALL = 1'b1;
                if (DMEM_ACK) begin
                    ack_take   = 1'b1;
                    state_next = DONE;
                end else if (count == TIMEOUT_LAST) begin
                    timed_out  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // MEM/WB has no enable, so every stalled cycle must be a bubble.
    assign WB_BUBBLE = PIPE_STALL | bad_access;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            DMEM_REQ   <= 1'b0;
            DMEM_WE    <= 1'b0;
            DMEM_ADDR  <= '0;
            DMEM_WDATA <= '0;
            RD_DATA    <= '0;
            count      <= 8'd0;
            MEM_ERR    <= 1'b0;
        end else begin
            if (issue) begin
                DMEM_REQ   <= 1'b1;
                DMEM_WE    <= MEM_WRITE;
                DMEM_ADDR  <= MEM_ADDR;
                DMEM_WDATA <= MEM_WDATA;
                count      <= 8'd0;
            end else if (state == BUSY) begin
                count <= count + 8'd1;
            end
            if (ack_take) begin
                DMEM_REQ <= 1'b0;
                if (!DMEM_WE) begin
                    RD_DATA <= DMEM_RDATA;
                end
            end
            if (timed_out) begin
                DMEM_REQ <= 1'b0;
                MEM_ERR  <= 1'b1;
                RD_DATA  <= '0;
            end
            if (bad_access) begin
                MEM_ERR <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences multi-cycle data-memory accesses for the MEM stage of the 5-stage MIPS pipeline.
- Issues the load or store request to the data memory and stalls the IF/ID/EX/MEM stages until the access completes.
- Injects bubbles into the MEM/WB register while stalled, and registers load data for MEM/WB capture.
- Detects misaligned addresses and memory timeouts.

Parameters:
- TIMEOUT, 255, maximum cycles to wait for DMEM_ACK after a request is issued (1..255).
- DATA_W, 32, data and address width.

Ports:
- CLK  in  1  clock
- RESET  in  1  reset, asynchronous, active-high
- MEM_READ  in  1  load in MEM stage (from EX/MEM control)
- MEM_WRITE  in  1  store in MEM stage
- MEM_ADDR  in  32  effective address (EX/MEM ALU result)
- MEM_WDATA  in  32  store data
- DMEM_REQ  out  1  request to data memory
- DMEM_WE  out  1  1 = write, 0 = read; valid while DMEM_REQ is high
- DMEM_ADDR  out  32  registered request address
- DMEM_WDATA  out  32  registered store data
- DMEM_ACK  in  1  one-cycle completion pulse from data memory
- DMEM_RDATA  in  32  load data, valid when DMEM_ACK is high
- RD_DATA  out  32  registered load result, feeds the MEM/WB RD-data input
- PIPE_STALL  out  1  hold the PC and the IF/ID, ID/EX and EX/MEM registers
- WB_BUBBLE  out  1  force MEM/WB control bits to 0 this cycle
- MEM_ERR  out  1  sticky error flag (misaligned access or timeout)

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE.
  - DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, RD_DATA, timeout counter and MEM_ERR all = 0.
  - Reset mid-access abandons the access; the memory must tolerate a dropped request.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Access request = MEM_READ | MEM_WRITE.
  - If both MEM_READ and MEM_WRITE are high, the access is treated as a write.
  - Misaligned (MEM_ADDR[1:0] != 0) and access requested:
    - No request is issued; MEM_ERR is set.
    - WB_BUBBLE = 1 for that cycle; no stall; stay in IDLE.
  - Aligned and access requested:
    - PIPE_STALL = 1 combinationally in the same cycle.
    - At the clock edge: DMEM_REQ <= 1, DMEM_WE <= MEM_WRITE, DMEM_ADDR <= MEM_ADDR, DMEM_WDATA <= MEM_WDATA, counter <= 0, go to BUSY.
  - No access requested: no stall, no bubble.
- BUSY:
  - PIPE_STALL = 1.
  - DMEM_REQ, DMEM_WE, DMEM_ADDR and DMEM_WDATA are held stable.
  - Counter increments every cycle.
  - DMEM_ACK = 1:
    - DMEM_REQ <= 0.
    - If the access is a read, RD_DATA <= DMEM_RDATA; writes leave RD_DATA unchanged.
    - Go to DONE.
  - Counter reaches TIMEOUT-1 with no ACK:
    - DMEM_REQ <= 0, MEM_ERR <= 1, RD_DATA <= 0, go to DONE.
  - ACK on the same cycle as the timeout: ACK wins, and MEM_ERR is not set.
- DONE:
  - PIPE_STALL = 0, so the pipeline advances at the end of this cycle and MEM/WB latches RD_DATA.
  - MEM_READ and MEM_WRITE are ignored, because they still describe the completed instruction.
  - Unconditionally go to IDLE.
- WB_BUBBLE = PIPE_STALL | (IDLE & misaligned access).
  - Because MEM/WB has no enable, this prevents a stalled instruction from writing back repeatedly.
- DMEM_ACK outside BUSY is ignored.
- MEM_ERR stays at 1 until RESET.
- Latency and throughput:
  - Back-to-back accesses: minimum 3 cycles per access (IDLE→BUSY→DONE) when ACK arrives the first BUSY cycle.
  - Total stall cycles = 1 + cycles spent in BUSY.
- Non-memory instructions pass with zero added latency.

Test Plan:
- Reset mid-BUSY: assert RESET while DMEM_REQ = 1 -> all outputs 0 immediately (asynchronous) and state IDLE; after release, a load proceeds normally.
- Aligned load: MEM_READ = 1, MEM_ADDR = 0x0000_0010, memory ACKs 2 cycles after REQ with DMEM_RDATA = 0x1234_5678 -> DMEM_REQ high for exactly 2 cycles, DMEM_WE = 0, DMEM_ADDR = 0x10, PIPE_STALL and WB_BUBBLE high for 3 cycles, RD_DATA = 0x1234_5678 in the DONE cycle, MEM_ERR = 0.
- Store then immediate load: MEM_WRITE with MEM_WDATA = 0xCAFE_F00D, ACK after 1 cycle, then MEM_READ presented at the next IDLE -> DMEM_WE = 1 with correct data, RD_DATA unchanged by the store, DONE cycle ignores inputs, second request issued from IDLE, no lost or duplicated request.
- Misaligned: MEM_READ = 1, MEM_ADDR = 0x0000_0013 -> DMEM_REQ stays 0, WB_BUBBLE = 1 for one cycle, PIPE_STALL = 0, MEM_ERR = 1 and stays 1.
- Timeout with TIMEOUT = 4: read issued, DMEM_ACK never asserted -> DMEM_REQ drops after 4 BUSY cycles, MEM_ERR = 1, RD_DATA = 0, one DONE cycle, then back to IDLE; a late ACK in IDLE is ignored.
- ACK coincident with the timeout cycle: TIMEOUT = 4, ACK in the 4th BUSY cycle with DMEM_RDATA = 0xA5A5_A5A5 -> RD_DATA = 0xA5A5_A5A5, MEM_ERR = 0.
